// File: rtl/test_i17270.sv
// Serial-stream monitor: overlapping "1101" pattern FSM plus a
// saturating run-of-ones counter, OR-ed into one registered-state flag.
module test_i17270 (
    input  logic N,
    input  logic CK,
    input  logic reset,
    output logic output_single
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S1   = 3'd1;
    localparam logic [2:0] S11  = 3'd2;
    localparam logic [2:0] S110 = 3'd3;
    localparam logic [2:0] HIT  = 3'd4;

    localparam logic [2:0] RUN_MAX = 3'd7;
    localparam logic [2:0] RUN_HIT = 3'd5;

    logic [2:0] r_state;
    logic [2:0] r_run_cnt;
    logic [2:0] w_state_nxt;
    logic [2:0] w_run_nxt;

    // Pattern FSM next-state; HIT falls back to S11 so "1101101" hits twice
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = N ? S1   : IDLE;
            S1:      w_state_nxt = N ? S11  : IDLE;
            S11:     w_state_nxt = N ? S11  : S110;
            S110:    w_state_nxt = N ? HIT  : IDLE;
            HIT:     w_state_nxt = N ? S11  : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Run counter next value: clear on a zero, saturate instead of wrapping
    always_comb begin
        w_run_nxt = 3'd0;
        if (N) begin
            w_run_nxt = (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + 3'd1;
        end
    end

    // Register both elements; reset wins over the data bit
    always_ff @(posedge CK) begin
        if (reset) begin
            r_state   <= IDLE;
            r_run_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_cnt <= w_run_nxt;
        end
    end

    // Moore decode: depends only on registers, never directly on N
    assign output_single = (r_state == HIT) || (r_run_cnt >= RUN_HIT);

endmodule

// File: tb/tb_test_i17270.sv
// Directed bench for test_i17270: hand-computed flag values after each
// edge for pattern, overlap, run saturation and reset-priority cases.
module tb_test_i17270;

    logic N;
    logic CK;
    logic reset;
    logic output_single;

    int n_chk;
    int n_pass;

    test_i17270 dut (
        .N            (N),
        .CK           (CK),
        .reset        (reset),
        .output_single(output_single)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Drive one edge's inputs, clock it, sample 1 time unit after the edge
    task automatic step(input logic n, input logic rst,
                        input logic exp, input string tag);
        N = n;
        reset = rst;
        @(posedge CK);
        #1;
        chk(tag, output_single, exp);
    endtask

    task automatic do_reset();
        N = 1'b0;
        reset = 1'b1;
        @(posedge CK);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        N = 1'b0;
        reset = 1'b0;
        #2;

        // reset, held across several edges
        step(1'b1, 1'b1, 1'b0, "rst_e1");
        step(1'b1, 1'b1, 1'b0, "rst_e2");
        step(1'b1, 1'b1, 1'b0, "rst_e3");

        // N=0 then N=1
        step(1'b0, 1'b0, 1'b0, "idle_0");
        step(1'b1, 1'b0, 1'b0, "idle_1");

        // basic 1101
        do_reset();
        step(1'b1, 1'b0, 1'b0, "p1101_e1");
        step(1'b1, 1'b0, 1'b0, "p1101_e2");
        step(1'b0, 1'b0, 1'b0, "p1101_e3");
        step(1'b1, 1'b0, 1'b1, "p1101_e4");
        step(1'b0, 1'b0, 1'b0, "p1101_e5");

        // overlapping 1101101
        do_reset();
        step(1'b1, 1'b0, 1'b0, "ovl_e1");
        step(1'b1, 1'b0, 1'b0, "ovl_e2");
        step(1'b0, 1'b0, 1'b0, "ovl_e3");
        step(1'b1, 1'b0, 1'b1, "ovl_e4");
        step(1'b1, 1'b0, 1'b0, "ovl_e5");
        step(1'b0, 1'b0, 1'b0, "ovl_e6");
        step(1'b1, 1'b0, 1'b1, "ovl_e7");

        // run of ten ones: flag from 5th on, no wrap after 8th
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, (i >= 5), $sformatf("run_e%0d", i));
        end
        // input glitch between edges must not move the flag
        N = 1'b0;
        #2;
        chk("glitch", output_single, 1'b1);
        N = 1'b1;
        #1;
        step(1'b0, 1'b0, 1'b0, "run_clr");
        step(1'b1, 1'b0, 1'b1, "run_hit");
        step(1'b1, 1'b0, 1'b0, "run_hit_end");

        // hit then run building up to the threshold
        do_reset();
        step(1'b1, 1'b0, 1'b0, "both_e1");
        step(1'b1, 1'b0, 1'b0, "both_e2");
        step(1'b0, 1'b0, 1'b0, "both_e3");
        step(1'b1, 1'b0, 1'b1, "both_e4");
        step(1'b1, 1'b0, 1'b0, "both_e5");
        step(1'b1, 1'b0, 1'b0, "both_e6");
        step(1'b1, 1'b0, 1'b0, "both_e7");
        step(1'b1, 1'b0, 1'b1, "both_e8");

        // reset beats N=1 while a run is active
        step(1'b1, 1'b1, 1'b0, "rst_prio_run");
        step(1'b1, 1'b0, 1'b0, "rst_prio_after");

        // partial match abandoned by reset, restart from IDLE
        do_reset();
        step(1'b1, 1'b0, 1'b0, "abn_e1");
        step(1'b1, 1'b0, 1'b0, "abn_e2");
        step(1'b0, 1'b0, 1'b0, "abn_e3");
        step(1'b1, 1'b1, 1'b0, "abn_rst");
        step(1'b1, 1'b0, 1'b0, "abn_e5");
        // from S1, 1,0,1 completes 1101
        step(1'b1, 1'b0, 1'b0, "abn_s1_a");
        step(1'b0, 1'b0, 1'b0, "abn_s1_b");
        step(1'b1, 1'b0, 1'b1, "abn_s1_c");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/test_i17270.md
TEST_I17270 -- requirements
Module: test_I17270

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The port list SHALL be in this order: N, CK, reset, output_single.
REQ-003 Port CK SHALL be an input, 1 bit wide: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port N SHALL be an input, 1 bit wide: serial data bit, sampled on each rising edge of CK.
REQ-006 Port output_single SHALL be an output, 1 bit wide: detection flag.
REQ-007 Clocking and reset (already decided): one clock; reset is synchronous and active-high.

Function
REQ-008 The block SHALL be a serial-stream monitor with two registered elements: a pattern FSM and a run-length counter.
REQ-009 The FSM SHALL have exactly five states:
- IDLE: no prefix matched.
- S1: "1" matched.
- S11: "11" matched.
- S110: "110" matched.
- HIT: "1101" just completed.
REQ-010 The FSM transitions per rising edge, as (N=0 -> next state, N=1 -> next state), SHALL be:
- IDLE: (IDLE, S1)
- S1: (IDLE, S11)
- S11: (S110, S11)
- S110: (IDLE, HIT)
- HIT: (IDLE, S11)
REQ-011 Pattern "1101" detection SHALL be overlapping, as given by the HIT transitions in REQ-010.
REQ-012 The block SHALL hold a 3-bit run counter run_cnt that counts consecutive N=1 samples.
REQ-013 run_cnt SHALL increment by 1 on each edge with N=1 and saturate at 7 (no wrap-around).
REQ-014 run_cnt SHALL clear to 0 on any edge with N=0.
REQ-015 output_single SHALL be a Moore decode of the registers: 1 when state==HIT OR run_cnt>=5, otherwise 0.
REQ-016 output_single SHALL have no combinational path from N.
REQ-017 Latency: output_single SHALL rise after the same edge that samples the final 1 of "1101", or the 5th consecutive 1.
REQ-018 A HIT-only assertion SHALL last exactly one cycle unless the run condition holds at the same time.
REQ-019 A run assertion SHALL persist while N stays 1 and SHALL clear on the first edge that samples N=0.
REQ-020 When both conditions hold simultaneously, output_single SHALL be 1, with no double-count or other side effect.
REQ-021 The FSM and run_cnt SHALL update independently on the same edge.
REQ-022 Output and state SHALL be insensitive to N between clock edges.

Reset
REQ-023 While reset=1 at a rising edge, the block SHALL load state=IDLE and run_cnt=0, so output_single=0 after that edge.
REQ-024 reset SHALL take priority over N on the same edge.
REQ-025 An asserted reset SHALL abandon any partial match or run; matching SHALL restart from IDLE afterwards.
REQ-026 Before the first reset edge, the output value is don't-care.
REQ-027 Reset SHALL hold its state across multiple consecutive edges while asserted.

Verification
REQ-028 Reset high for 1 edge -> output_single=0, state=IDLE, run_cnt=0.
REQ-029 After reset, N=0 for one edge then N=1 for one edge -> output_single=0 after both edges.
REQ-030 N=1,1,0,1 -> output_single=0 after edges 1-3 and 1 after edge 4; then N=0 -> output_single=0.
REQ-031 N=1,1,0,1,1,0,1 -> output_single=1 only after edges 4 and 7 (overlap check).
REQ-032 N=1 for 8 edges then N=0 -> output_single=1 after edges 5 through 8 (run_cnt saturates at 7), and 0 after the N=0 edge.
REQ-033 N=1,1,0, then reset=1 for one edge, then N=1 -> output_single stays 0 throughout; state=S1 after the final edge.
